tdc_uart_rx: RTL
================

# tdc_uart_rx

UART 8N1 receiver for the TDC chip. It is the receive-side counterpart of the measurement-frame transmitter on `tx`, and gives the host a return path for commands and loop-back checks. The block synchronizes the serial input, rejects start-bit glitches, samples each bit at mid-bit, checks the stop bit, and presents each received byte through a one-deep valid/ready holding register. It sits beside the TDC transmitter in the top-level wrapper, fed from a dedicated input pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Legal range is ≥ 4. Counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, idle high. Asynchronous to `clk`.
- `data` out 8: received byte. Valid while `valid`=1.
- `valid` out 1: holding register full.
- `ready` in 1: consumer accepts `data` when `valid & ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled 0.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the holding register is full.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer to give `rx_s`. The synchronizer resets to 1.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rx_s`=0, go to START and clear the counter.
- START: count HALF = `CLKS_PER_BIT/2` (integer division) cycles, then sample `rx_s`.
  - If `rx_s`=1, it was a glitch: return to IDLE with no outputs.
  - If `rx_s`=0, go to DATA.
- DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into a shift register. After bit 7, go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
  - If `rx_s`=1, offer the byte to the holding register and go to IDLE, ready for a new start.
  - If `rx_s`=0, pulse `frame_err`, discard the byte and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This covers break conditions.
- Holding register:
  - When the stop bit is good and either `valid`=0, or `valid & ready` in the same cycle, load `data` and set `valid`=1.
  - When the stop bit is good, `valid`=1 and `ready`=0, keep the old byte, drop the new one and pulse `overrun`.
  - `valid & ready` with no load clears `valid` on the next edge.
  - `data` must not change while `valid`=1 unless the byte was consumed in that cycle.
- A `frame_err` never touches the holding register.
- Reset values: state IDLE, `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, shift register 0, counters 0.
- Reset asserted mid-frame aborts immediately. After release the FSM waits for a new falling edge; a partial frame is never delivered.

## Timing
- t0 is the first `clk` edge at which `rx_s`=0 in IDLE. This is 2 to 3 cycles after the pin falls.
- The start bit is sampled at t0+HALF.
- Data bit i (i = 0..7) is sampled at t0 + HALF + (i+1)·`CLKS_PER_BIT`.
- The stop bit is sampled at t0 + HALF + 9·`CLKS_PER_BIT`.
- `valid`, `frame_err` or `overrun` is registered 1 cycle after the stop sample.
- `busy` rises at t0+1 and falls in the cycle after the stop sample.
- Back-to-back frames with zero idle bits are received without loss. The FSM is back in IDLE half a bit before the nominal stop end.
- Consumer throughput is 1 byte per cycle. `ready` may be held high permanently.

## Test plan
With `CLKS_PER_BIT`=16:
1. Send 0x55 with `ready`=1. Required: `valid` for exactly 1 cycle with `data`=0x55, registered 1 cycle after the stop sample at t0+8+144. No error pulses.
2. Drive `rx` low for 4 cycles, then high. Required: `busy` pulses high and returns low, with no `valid`, `frame_err` or `overrun`. Then send 0xA3. Required: 0xA3 is received correctly.
3. Send 0x0F with the stop bit forced to 0 for 3 bits, then return high. Required: `frame_err` pulses exactly once, `valid` stays 0, and a following 0x81 is received.
4. With `ready`=0, send 0x3C and then 0xC3. Required: `data` stays 0x3C with `valid`=1, and `overrun` pulses once at the end of 0xC3. Then raise `ready` for 1 cycle. Required: `valid` drops.
5. Send 0x00, 0xFF and 0x5A back-to-back with no idle time and `ready`=1. Required: three `valid` pulses with the correct bytes, spaced 10·16 cycles apart.
6. Assert `rst_n`=0 during bit 4 of 0x99. Required: all outputs return to reset values immediately. After release, the remainder of that frame produces no `valid`, and a new 0x66 is received correctly.

Source files
------------

// File: rtl/tdc_uart_rx.sv
// tdc_uart_rx: 8N1 UART receiver with start-glitch rejection, mid-bit sampling,
// stop-bit checking and a one-deep valid/ready holding register.
module tdc_uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             rx_m, rx_s;
  logic             good_stop, bad_stop;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  // Next-state logic: half-bit start check, then full-bit spaced samples
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shift_n   = shift;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            good_stop = 1'b1;
            state_n   = IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_n   = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Holding register: a consumer handshake in the same cycle frees the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good_stop & valid & ~ready;
      if (good_stop && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
